// File: rtl/mem_cmd_scheduler_pkg.sv
// Shared types for the memory command scheduler: packed command layout and FSM states.
package mem_cmd_scheduler_pkg;

  localparam int CMD_WIDTH = 65;
  localparam int LEN_WIDTH = 32;

  typedef struct packed {
    logic        read_not_write;
    logic [31:0] address;
    logic [31:0] length;
  } MemoryCommand;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mem_cmd_scheduler_tag_queue.sv
// Read tag FIFO: holds {client index, length} for each read issued to memory, head visible combinationally.
module mem_tag_queue #(
  parameter int depth       = 4,
  parameter int entry_width = 33
) (
  input  logic                     clk_mem,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [entry_width-1:0]   push_data,
  input  logic                     pop,
  output logic [entry_width-1:0]   head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [entry_width-1:0] store_reg [depth];
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic                   do_push;
  logic                   do_pop;

  assign count     = wr_ptr_reg - rd_ptr_reg;
  assign full      = (count == (AW+1)'(depth));
  assign empty     = (count == '0);
  assign head_data = store_reg[rd_ptr_reg[AW-1:0]];
  assign do_pop    = pop && !empty;
  // A push while full is only safe when the head slot is vacated in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (do_push) store_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_cmd_scheduler.sv
// Round-robin scheduler sharing one memory command/write/read FIFO set between several clients.
module mem_cmd_scheduler
  import mem_cmd_scheduler_pkg::*;
#(
  parameter int num_clients     = 2,
  parameter int mem_width       = 32,
  parameter int cmd_width       = CMD_WIDTH,
  parameter int max_outstanding = 4
) (
  input  logic                             clk_mem,
  input  logic                             reset_n,
  input  logic [num_clients-1:0]           cli_cmd_valid,
  output logic [num_clients-1:0]           cli_cmd_ready,
  input  logic [num_clients*cmd_width-1:0] cli_cmd_data,
  input  logic [num_clients-1:0]           cli_wr_valid,
  output logic [num_clients-1:0]           cli_wr_ready,
  input  logic [num_clients*mem_width-1:0] cli_wr_data,
  output logic [num_clients-1:0]           cli_rd_valid,
  input  logic [num_clients-1:0]           cli_rd_ready,
  output logic [num_clients*mem_width-1:0] cli_rd_data,
  output logic                             mem_cmd_valid,
  input  logic                             mem_cmd_ready,
  output logic [cmd_width-1:0]             mem_cmd_data,
  output logic                             mem_wr_valid,
  input  logic                             mem_wr_ready,
  output logic [mem_width-1:0]             mem_wr_data,
  input  logic                             mem_rd_valid,
  output logic                             mem_rd_ready,
  input  logic [mem_width-1:0]             mem_rd_data,
  output logic [$clog2(num_clients)-1:0]   grant_index,
  output logic                             busy
);

  localparam int GW    = $clog2(num_clients);
  localparam int TAG_W = GW + LEN_WIDTH;
  localparam int QCW   = $clog2(max_outstanding) + 1;

  sched_state_t   state_reg, state_next;
  MemoryCommand   cmd_reg, cmd_next;
  logic [GW-1:0]  grant_reg, grant_next;
  logic [31:0]    wr_count_reg, wr_count_next;
  logic [31:0]    rd_count_reg, rd_count_next;

  MemoryCommand          cli_cmd     [num_clients];
  logic [mem_width-1:0]  cli_wr_word [num_clients];
  logic [num_clients-1:0] eligible;
  logic                  found;
  logic [GW-1:0]         winner;
  int                    idx;

  logic             tag_push, tag_pop, tag_full, tag_empty;
  logic [TAG_W-1:0] tag_head;
  logic [QCW-1:0]   tag_count;
  logic [GW-1:0]    head_client;
  logic [31:0]      head_len;
  logic             rd_hs;

  generate
    for (genvar gi = 0; gi < num_clients; gi++) begin : g_cli
      assign cli_cmd[gi]     = cli_cmd_data[gi*cmd_width +: cmd_width];
      assign cli_wr_word[gi] = cli_wr_data[gi*mem_width +: mem_width];
      assign cli_rd_data[gi*mem_width +: mem_width] = mem_rd_data;
      // Reads are skipped while no tag slot is free, so writes keep flowing.
      assign eligible[gi] = cli_cmd_valid[gi] && !(cli_cmd[gi].read_not_write && tag_full);
    end
  endgenerate

  always_comb begin
    found  = 1'b0;
    winner = grant_reg;
    idx    = 0;
    for (int i = 1; i <= num_clients; i++) begin
      idx = (int'(grant_reg) + i) % num_clients;
      if (!found && eligible[GW'(idx)]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    grant_next    = grant_reg;
    wr_count_next = wr_count_reg;
    cli_cmd_ready = '0;
    cli_wr_ready  = '0;
    mem_cmd_valid = 1'b0;
    mem_wr_valid  = 1'b0;
    mem_wr_data   = cli_wr_word[grant_reg];
    tag_push      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (found && reset_n) begin
          cli_cmd_ready[winner] = 1'b1;
          cmd_next              = cli_cmd[winner];
          grant_next            = winner;
          if (cli_cmd[winner].length != '0) state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          if (cmd_reg.read_not_write) begin
            tag_push   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            wr_count_next = '0;
            state_next    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        mem_wr_valid            = cli_wr_valid[grant_reg];
        cli_wr_ready[grant_reg] = mem_wr_ready;
        if (cli_wr_valid[grant_reg] && mem_wr_ready) begin
          if (wr_count_reg == cmd_reg.length - 32'd1) begin
            wr_count_next = '0;
            state_next    = ST_IDLE;
          end else begin
            wr_count_next = wr_count_reg + 32'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read return path runs independently of the issue FSM, steered by the tag queue head.
  assign head_client = tag_head[TAG_W-1 -: GW];
  assign head_len    = tag_head[LEN_WIDTH-1:0];

  always_comb begin
    cli_rd_valid = '0;
    mem_rd_ready = 1'b0;
    if (!tag_empty) begin
      cli_rd_valid[head_client] = mem_rd_valid;
      mem_rd_ready              = cli_rd_ready[head_client];
    end
  end

  assign rd_hs   = mem_rd_valid && mem_rd_ready;
  assign tag_pop = rd_hs && (rd_count_reg == head_len - 32'd1);

  always_comb begin
    rd_count_next = rd_count_reg;
    if (tag_pop)    rd_count_next = '0;
    else if (rd_hs) rd_count_next = rd_count_reg + 32'd1;
  end

  mem_tag_queue #(
    .depth       (max_outstanding),
    .entry_width (TAG_W)
  ) u_tag_queue (
    .clk_mem   (clk_mem),
    .reset_n   (reset_n),
    .push      (tag_push),
    .push_data ({grant_reg, cmd_reg.length}),
    .pop       (tag_pop),
    .head_data (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      grant_reg    <= '0;
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      grant_reg    <= grant_next;
      wr_count_reg <= wr_count_next;
      rd_count_reg <= rd_count_next;
    end
  end

  assign mem_cmd_data = cmd_reg;
  assign grant_index  = grant_reg;
  assign busy         = (state_reg != ST_IDLE) || (tag_count != '0);

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Directed bench for mem_cmd_scheduler: write issue, arbitration, read steering, stalls and reset.
module tb_mem_cmd_scheduler;

  localparam int NC = 2;
  localparam int MW = 32;
  localparam int CW = 65;

  logic             clk_mem = 1'b0;
  logic             reset_n;
  logic [NC-1:0]    cli_cmd_valid, cli_cmd_ready;
  logic [NC*CW-1:0] cli_cmd_data;
  logic [NC-1:0]    cli_wr_valid, cli_wr_ready;
  logic [NC*MW-1:0] cli_wr_data;
  logic [NC-1:0]    cli_rd_valid, cli_rd_ready;
  logic [NC*MW-1:0] cli_rd_data;
  logic             mem_cmd_valid, mem_cmd_ready;
  logic [CW-1:0]    mem_cmd_data;
  logic             mem_wr_valid, mem_wr_ready;
  logic [MW-1:0]    mem_wr_data;
  logic             mem_rd_valid, mem_rd_ready;
  logic [MW-1:0]    mem_rd_data;
  logic             grant_index;
  logic             busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_mem = ~clk_mem;

  mem_cmd_scheduler #(
    .num_clients(NC), .mem_width(MW), .cmd_width(CW), .max_outstanding(4)
  ) dut (
    .clk_mem(clk_mem), .reset_n(reset_n),
    .cli_cmd_valid(cli_cmd_valid), .cli_cmd_ready(cli_cmd_ready), .cli_cmd_data(cli_cmd_data),
    .cli_wr_valid(cli_wr_valid), .cli_wr_ready(cli_wr_ready), .cli_wr_data(cli_wr_data),
    .cli_rd_valid(cli_rd_valid), .cli_rd_ready(cli_rd_ready), .cli_rd_data(cli_rd_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_data(mem_cmd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .grant_index(grant_index), .busy(busy)
  );

  task automatic step();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    cli_cmd_valid = '0;
    cli_cmd_data  = '0;
    cli_wr_valid  = '0;
    cli_wr_data   = '0;
    cli_rd_ready  = '0;
    mem_cmd_ready = 1'b1;
    mem_wr_ready  = 1'b1;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = '0;
  endtask

  task automatic post_cmd(input int c, input logic rnw, input logic [31:0] addr, input logic [31:0] len);
    cli_cmd_valid[c]          = 1'b1;
    cli_cmd_data[c*CW +: CW]  = {rnw, addr, len};
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    cli_cmd_valid = 2'b11;
    reset_n = 1'b0;
    step();
    step();
    n_vec++; if (cli_cmd_ready !== 2'b00) begin n_bad++; $display("FAIL rst_cmd_ready got %b want 00", cli_cmd_ready); end
    n_vec++; if ({mem_cmd_valid, mem_wr_valid, mem_rd_ready} !== 3'b000) begin n_bad++; $display("FAIL rst_mem_ctl got %b want 000", {mem_cmd_valid, mem_wr_valid, mem_rd_ready}); end
    n_vec++; if ({cli_rd_valid, cli_wr_ready} !== 4'b0000) begin n_bad++; $display("FAIL rst_cli_ctl got %b want 0000", {cli_rd_valid, cli_wr_ready}); end
    n_vec++; if ({grant_index, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_grant_busy got %b want 00", {grant_index, busy}); end
    cli_cmd_valid = 2'b00;
    reset_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_write();
    logic [MW-1:0] w;
    post_cmd(0, 1'b0, 32'h100, 32'd4);
    settle();
    n_vec++; if (cli_cmd_ready !== 2'b01) begin n_bad++; $display("FAIL wr_accept got %b want 01", cli_cmd_ready); end
    n_vec++; if (mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL wr_cmd_early got %b want 0", mem_cmd_valid); end
    mem_cmd_ready = 1'b0;
    step();
    cli_cmd_valid = '0;
    settle();
    n_vec++; if (mem_cmd_data !== 65'h0_00000100_00000004) begin n_bad++; $display("FAIL wr_cmd_data got %h want 0_00000100_00000004", mem_cmd_data); end
    step();
    n_vec++; if (mem_cmd_valid !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_hold got %b want 1", mem_cmd_valid); end
    mem_cmd_ready = 1'b1;
    step();
    n_vec++; if (mem_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL wr_cmd_drop got %b want 0", mem_cmd_valid); end
    for (int i = 0; i < 4; i++) begin
      w = 32'hA0A0_0000 + 32'(i);
      cli_wr_valid[0] = 1'b1;
      cli_wr_data[MW-1:0] = w;
      if (i == 2) begin
        mem_wr_ready = 1'b0;
        settle();
        n_vec++; if ({mem_wr_valid, cli_wr_ready} !== 3'b100) begin n_bad++; $display("FAIL wr_stall got %b want 100", {mem_wr_valid, cli_wr_ready}); end
        step();
        mem_wr_ready = 1'b1;
      end
      settle();
      n_vec++; if (mem_wr_data !== w) begin n_bad++; $display("FAIL wr_word%0d got %h want %h", i, mem_wr_data, w); end
      n_vec++; if ({mem_wr_valid, cli_wr_ready} !== 3'b101) begin n_bad++; $display("FAIL wr_hs%0d got %b want 101", i, {mem_wr_valid, cli_wr_ready}); end
      step();
      $display("write word %0d = %h", i, w);
    end
    cli_wr_valid = '0;
    settle();
    n_vec++; if ({busy, mem_wr_valid, cli_wr_ready} !== 4'b0000) begin n_bad++; $display("FAIL wr_done got %b want 0000", {busy, mem_wr_valid, cli_wr_ready}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq;
    int c;
    exp_seq = 4'b0101;
    apply_reset();
    post_cmd(0, 1'b1, 32'h200, 32'd1);
    post_cmd(1, 1'b1, 32'h300, 32'd1);
    for (int k = 0; k < 4; k++) begin
      c = exp_seq[k] ? 1 : 0;
      settle();
      n_vec++; if (cli_cmd_ready !== (c == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_ready%0d got %b want client %0d", k, cli_cmd_ready, c); end
      step();
      n_vec++; if (grant_index !== exp_seq[k]) begin n_bad++; $display("FAIL rr_grant%0d got %0d want %0d", k, grant_index, c); end
      n_vec++; if (mem_cmd_data[63:32] !== (c == 1 ? 32'h300 : 32'h200)) begin n_bad++; $display("FAIL rr_addr%0d got %h", k, mem_cmd_data[63:32]); end
      step();
      $display("round robin grant %0d -> client %0d", k, c);
    end
    settle();
    n_vec++; if ({cli_cmd_ready, busy} !== 3'b001) begin n_bad++; $display("FAIL rr_full got %b want 001", {cli_cmd_ready, busy}); end
    cli_cmd_valid = '0;
    cli_rd_ready = 2'b11;
    mem_rd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c = exp_seq[k] ? 1 : 0;
      mem_rd_data = 32'hD000_0000 + 32'(k);
      settle();
      n_vec++; if (cli_rd_valid !== (c == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_rd_route%0d got %b want client %0d", k, cli_rd_valid, c); end
      n_vec++; if (cli_rd_data[c*MW +: MW] !== mem_rd_data) begin n_bad++; $display("FAIL rr_rd_data%0d got %h want %h", k, cli_rd_data[c*MW +: MW], mem_rd_data); end
      step();
    end
    mem_rd_valid = 1'b0;
    settle();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_drain_busy got %b want 0", busy); end
  endtask

  task automatic test_read_return();
    int c;
    logic [MW-1:0] d;
    apply_reset();
    post_cmd(1, 1'b1, 32'h400, 32'd3);
    step();
    cli_cmd_valid = '0;
    step();
    post_cmd(0, 1'b1, 32'h500, 32'd2);
    step();
    cli_cmd_valid = '0;
    step();
    cli_rd_ready = 2'b11;
    mem_rd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c = (k < 3) ? 1 : 0;
      d = 32'hB000_0000 + 32'(k);
      mem_rd_data = d;
      settle();
      n_vec++; if ({cli_rd_valid, mem_rd_ready} !== (c == 1 ? 3'b101 : 3'b011)) begin n_bad++; $display("FAIL ret_route%0d got %b want client %0d", k, {cli_rd_valid, mem_rd_ready}, c); end
      n_vec++; if (cli_rd_data[c*MW +: MW] !== d) begin n_bad++; $display("FAIL ret_data%0d got %h want %h", k, cli_rd_data[c*MW +: MW], d); end
      step();
      $display("read word %0d -> client %0d = %h", k, c, d);
    end
    settle();
    n_vec++; if ({cli_rd_valid, mem_rd_ready} !== 3'b000) begin n_bad++; $display("FAIL ret_after got %b want 000", {cli_rd_valid, mem_rd_ready}); end
    mem_rd_valid = 1'b0;
  endtask

  task automatic test_rd_stall();
    int stall_bad;
    apply_reset();
    post_cmd(0, 1'b1, 32'h600, 32'd3);
    step();
    cli_cmd_valid = '0;
    step();
    mem_rd_valid = 1'b1;
    cli_rd_ready = 2'b01;
    mem_rd_data = 32'hC000_0000;
    settle();
    n_vec++; if (cli_rd_data[MW-1:0] !== 32'hC000_0000) begin n_bad++; $display("FAIL stall_w0 got %h want c0000000", cli_rd_data[MW-1:0]); end
    step();
    cli_rd_ready = 2'b00;
    mem_rd_data = 32'hC000_0001;
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      n_vec++; if ({mem_rd_ready, cli_rd_valid} !== 3'b001) begin n_bad++; stall_bad++; $display("FAIL stall_cycle%0d got %b want 001", k, {mem_rd_ready, cli_rd_valid}); end
      step();
    end
    cli_rd_ready = 2'b01;
    for (int k = 1; k < 3; k++) begin
      mem_rd_data = 32'hC000_0000 + 32'(k);
      settle();
      n_vec++; if ({mem_rd_ready, cli_rd_data[MW-1:0]} !== {1'b1, mem_rd_data}) begin n_bad++; $display("FAIL stall_w%0d got %b/%h want 1/%h", k, mem_rd_ready, cli_rd_data[MW-1:0], mem_rd_data); end
      step();
    end
    mem_rd_valid = 1'b0;
    settle();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy got %b want 0", busy); end
    $display("read stall test done, stalled cycles with errors: %0d", stall_bad);
  endtask

  task automatic test_tag_full();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      post_cmd(0, 1'b1, 32'h700 + 32'(k), 32'd1);
      settle();
      n_vec++; if (cli_cmd_ready !== 2'b01) begin n_bad++; $display("FAIL full_rd%0d got %b want 01", k, cli_cmd_ready); end
      step();
      step();
    end
    post_cmd(1, 1'b0, 32'h800, 32'd1);
    settle();
    n_vec++; if (cli_cmd_ready !== 2'b10) begin n_bad++; $display("FAIL full_skip got %b want 10", cli_cmd_ready); end
    step();
    cli_cmd_valid[1] = 1'b0;
    settle();
    n_vec++; if (mem_cmd_data !== {1'b0, 32'h800, 32'd1}) begin n_bad++; $display("FAIL full_wcmd got %h", mem_cmd_data); end
    step();
    cli_wr_valid[1] = 1'b1;
    cli_wr_data[MW +: MW] = 32'hEEEE_0001;
    settle();
    n_vec++; if ({mem_wr_data, cli_wr_ready} !== {32'hEEEE_0001, 2'b10}) begin n_bad++; $display("FAIL full_wdata got %h/%b", mem_wr_data, cli_wr_ready); end
    step();
    cli_wr_valid = '0;
    settle();
    n_vec++; if ({cli_cmd_ready, mem_wr_valid} !== 3'b000) begin n_bad++; $display("FAIL full_wait got %b want 000", {cli_cmd_ready, mem_wr_valid}); end
    mem_rd_valid = 1'b1;
    cli_rd_ready = 2'b01;
    settle();
    n_vec++; if (mem_rd_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_rdy got %b want 1", mem_rd_ready); end
    step();
    mem_rd_valid = 1'b0;
    settle();
    n_vec++; if (cli_cmd_ready !== 2'b01) begin n_bad++; $display("FAIL full_5th got %b want 01", cli_cmd_ready); end
    step();
    cli_cmd_valid = '0;
    step();
    $display("tag full test done");
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    post_cmd(0, 1'b0, 32'h900, 32'd4);
    step();
    cli_cmd_valid = '0;
    step();
    cli_wr_valid[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cli_wr_data[MW-1:0] = 32'hF000_0000 + 32'(k);
      step();
    end
    cli_wr_data[MW-1:0] = 32'hF000_0002;
    settle();
    n_vec++; if (mem_wr_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %b want 1", mem_wr_valid); end
    reset_n = 1'b0;
    #1;
    n_vec++; if ({mem_wr_valid, cli_wr_ready, mem_cmd_valid} !== 4'b0000) begin n_bad++; $display("FAIL mid_async got %b want 0000", {mem_wr_valid, cli_wr_ready, mem_cmd_valid}); end
    n_vec++; if ({busy, grant_index} !== 2'b00) begin n_bad++; $display("FAIL mid_busy got %b want 00", {busy, grant_index}); end
    cli_wr_valid = '0;
    step();
    reset_n = 1'b1;
    post_cmd(1, 1'b1, 32'hA00, 32'd2);
    settle();
    n_vec++; if (cli_cmd_ready !== 2'b10) begin n_bad++; $display("FAIL mid_next got %b want 10", cli_cmd_ready); end
    step();
    cli_cmd_valid = '0;
    settle();
    n_vec++; if ({mem_cmd_valid, mem_cmd_data} !== {1'b1, 1'b1, 32'hA00, 32'd2}) begin n_bad++; $display("FAIL mid_cmd got %b/%h", mem_cmd_valid, mem_cmd_data); end
    $display("reset mid write test done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read_return();
    test_rd_stall();
    test_tag_full();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_cmd_scheduler.md
Name: mem_cmd_scheduler

Overview:
- Shares the single external-memory command/write/read FIFO interface between num_clients requesters in the clk_mem domain.
- Requesters include the port FIFO arbiter's async-FIFO outputs and the host debug/DMA access path.
- Grants whole transactions round-robin: a command plus, for writes, exactly length write words.
- Tags outstanding reads so returning read words are steered back to the issuing client in order.

Parameters:
- num_clients, 2, number of requesters (≥2).
- mem_width, 32, data word width.
- cmd_width, 65, packed command: [64] read_not_write, [63:32] address, [31:0] length in words.
- max_outstanding, 4, depth of the read tag queue (power of 2).

Ports:
- clk_mem  in  1  memory-domain clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- cli_cmd_valid  in  [num_clients]x1  client command valid.
- cli_cmd_ready  out  [num_clients]x1  client command accepted.
- cli_cmd_data  in  [num_clients]xcmd_width  client command.
- cli_wr_valid  in  [num_clients]x1  client write data valid.
- cli_wr_ready  out  [num_clients]x1  client write data accepted.
- cli_wr_data  in  [num_clients]xmem_width  client write word.
- cli_rd_valid  out  [num_clients]x1  read word valid to client.
- cli_rd_ready  in  [num_clients]x1  client can take a read word.
- cli_rd_data  out  [num_clients]xmem_width  read word.
- mem_cmd_valid / mem_cmd_ready / mem_cmd_data  out/in/out  1/1/cmd_width  to memory command FIFO.
- mem_wr_valid / mem_wr_ready / mem_wr_data  out/in/out  1/1/mem_width  to memory write FIFO.
- mem_rd_valid / mem_rd_ready / mem_rd_data  in/out/in  1/1/mem_width  from memory read FIFO.
- grant_index  out  $clog2(num_clients)  currently or last granted client.
- busy  out  1  FSM not in IDLE or tag queue non-empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All valid/ready outputs 0; grant_index 0 (so the first search starts at client 1); busy 0.
  - State IDLE; tag queue emptied; all counters 0.
  - Reset mid-transaction abandons it; memory-side FIFOs must be reset together with this block.
- Handshake: transfer occurs when valid && ready on a rising edge. Valid, once raised by this block, stays high with stable data until accepted.
- FSM IDLE:
  - Eligible client: cli_cmd_valid high, and for reads the tag queue is not full.
  - Search starts at grant_index+1 modulo num_clients; the first eligible client wins.
  - Winner gets cli_cmd_ready=1 combinationally in that cycle; command is latched; grant_index updated.
  - length==0: command consumed, nothing issued, stay IDLE.
  - Otherwise go to CMD.
  - Ineligible reads are skipped, not stalled on.
- FSM CMD:
  - mem_cmd_valid=1 with the latched command; it first appears the cycle after acceptance.
  - On mem_cmd_ready, a read pushes {client, length} into the tag queue and returns to IDLE; a write goes to WRITE with wr_count=0.
- FSM WRITE:
  - mem_wr_valid=cli_wr_valid[g], mem_wr_data=cli_wr_data[g], cli_wr_ready[g]=mem_wr_ready; all other cli_wr_ready are 0.
  - Count handshakes; the handshake with wr_count==length-1 returns to IDLE.
  - No other command is issued during WRITE.
- Read return (independent of FSM):
  - Tag queue head h selects client: cli_rd_valid[h]=mem_rd_valid, cli_rd_data[h]=mem_rd_data, mem_rd_ready=cli_rd_ready[h].
  - Tag queue empty: mem_rd_ready=0 and all cli_rd_valid=0.
  - rd_count increments per handshake; at rd_count==length-1, pop the head and clear rd_count.
- Simultaneous push and pop of the tag queue in one cycle is legal; occupancy is unchanged.
- Widths: length and counters are 32 bits; no wrap within a transaction. Address passes through unmodified.

Decomposition:
- Shared package: MemoryCommand packed struct (read_not_write, address, length) and its width constant 65.
- One sub-module: mem_tag_queue, a synchronous FIFO of {client index, length} with full, empty and count outputs.

Test Plan:
- Client 0 write addr 0x100 length 4 with words A0..A3 → one mem_cmd of 0x0_00000100_00000004, then mem_wr carries A0..A3 in order; FSM returns to IDLE after the 4th word.
- Clients 0 and 1 post reads simultaneously and continuously → grants alternate 1,0,1,0 (search starts at client 1 after reset); no starvation.
- Client 1 read length 3, then client 0 read length 2; memory returns 5 words → first 3 go to client 1, last 2 to client 0; mem_rd_ready is 0 after the 5th word.
- max_outstanding=4 reads pending from client 0 while client 1 posts a write → client 1's write is granted; client 0's 5th read waits until a tag pops.
- Client 0 stalls cli_rd_ready for 10 cycles mid-burst → mem_rd_ready held low for those cycles; no data lost or reordered.
- reset_n pulsed low during WRITE word 2 of 4 → all outputs 0 immediately; busy=0; the next command is accepted normally.
